// File: rtl/rca6_add_sched.sv
// Scheduler that time-shares one external RCA6 between two requesters. It adds SLICES 6-bit slices per operation.
// Define RCA6_SCHED_RR_EN for round-robin tie-breaking; without it, req0 has fixed priority.
module rca6_add_sched #(
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [6*SLICES-1:0]   a0,
  input  logic [6*SLICES-1:0]   b0,
  input  logic [6*SLICES-1:0]   a1,
  input  logic [6*SLICES-1:0]   b1,
  input  logic                  cin0,
  input  logic                  cin1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [5:0]            add_a,
  output logic [5:0]            add_b,
  output logic                  add_cin,
  input  logic [5:0]            add_s,
  input  logic                  add_cout,
  output logic [6*SLICES-1:0]   sum,
  output logic                  cout,
  output logic                  done,
  output logic                  done_id,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int W  = 6 * SLICES;
  localparam int IW = $clog2(SLICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          carry;
  logic [IW-1:0] idx;
  logic          id;
  logic          pick1;
  logic          idle;

  assign idle = (state == S_IDLE) && !reset;

`ifdef RCA6_SCHED_RR_EN
  // last_gnt remembers who won most recently; a tie goes to the other requester.
  logic last_gnt;

  always_comb begin
    pick1 = req1 && (!req0 || !last_gnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (gnt0 || gnt1)
      last_gnt <= gnt1;
  end
`else
  always_comb begin
    pick1 = req1 && !req0;
  end
`endif

  assign gnt0 = idle && req0 && !pick1;
  assign gnt1 = idle && pick1;

  // The adder inputs are combinational from registers and stay 0 outside RUN.
  always_comb begin
    add_a   = 6'd0;
    add_b   = 6'd0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = op_a[6*int'(idx) +: 6];
      add_b   = op_b[6*int'(idx) +: 6];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      id      <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            op_a  <= gnt1 ? a1 : a0;
            op_b  <= gnt1 ? b1 : b0;
            carry <= gnt1 ? cin1 : cin0;
            idx   <= '0;
            id    <= gnt1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[6*int'(idx) +: 6] <= add_s;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout    <= add_cout;
            done_id <= id;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rca6_add_sched.sv
// Bench for rca6_add_sched: behavioural RCA6 model plus a scoreboard of W+1-bit sums.
// Arbitration expectations follow RCA6_SCHED_RR_EN.
module tb_rca6_add_sched;

  localparam int SLICES = 4;
  localparam int W      = 6 * SLICES;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          cin0, cin1;
  logic          gnt0, gnt1;
  logic [5:0]    add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic [W-1:0]  sum;
  logic          cout, done, done_id, busy;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;
  bit last_g   = 1'b1;
  logic [W+1:0] exp_q[$];

  rca6_add_sched #(.SLICES(SLICES)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .sum(sum), .cout(cout), .done(done), .done_id(done_id),
    .busy(busy), .state_dbg(state_dbg)
  );

  // External RCA6 stand-in.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {6'd0, add_cin};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_pick1(input bit r0, input bit r1);
`ifdef RCA6_SCHED_RR_EN
    return r1 && (!r0 || !last_g);
`else
    return r1 && !r0;
`endif
  endfunction

  function automatic logic [W+1:0] model_result(input bit id, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input bit c);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {full[W], id, full[W-1:0]};
  endfunction

  task automatic check_done(input string name);
    logic [W+1:0] exp;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: done with empty expected queue", name);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if ({cout, done_id, sum} !== exp) begin
        failures++;
        $display("FAIL %s: got cout=%0b id=%0b sum=%h, want cout=%0b id=%0b sum=%h",
                 name, cout, done_id, sum, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt0, gnt1, add_a, add_b, add_cin, sum, cout, done, done_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got sum=%h busy=%0b done=%0b add_a=%h", sum, busy, done, add_a);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%0b done=%0b state=%0d want 0 0 0", busy, done, state_dbg);
    end
  endtask

  // One operation from an idle DUT: grant expected at once, done SLICES+1 cycles later.
  task automatic do_op(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit c, output logic [SLICES-1:0] trace);
    trace = '0;
    @(posedge clk); #1;
    if (which) begin req1 = 1'b1; a1 = a; b1 = b; cin1 = c; end
    else       begin req0 = 1'b1; a0 = a; b0 = b; cin0 = c; end
    @(negedge clk);
    checks++;
    if (gnt0 !== !which || gnt1 !== which) begin
      failures++;
      $display("FAIL op_grant: got gnt0=%0b gnt1=%0b want requester %0d", gnt0, gnt1, which);
    end
    exp_q.push_back(model_result(which, a, b, c));
    last_g = which;
    for (int k = 1; k <= SLICES + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      if (k <= SLICES) begin
        trace[k-1] = add_cin;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL op_run: cycle %0d got busy=%0b done=%0b want 1 0", k, busy, done);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL op_done_timing: got done=%0b busy=%0b want 1 1", done, busy);
          void'(exp_q.pop_front());
        end else begin
          check_done("op_result");
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [SLICES-1:0] tr;
    do_op(1'b0, 24'h000010, 24'h000011, 1'b0, tr);
    checks++;
    if (sum !== 24'h000021 || cout !== 1'b0) begin
      failures++;
      $display("FAIL dir_simple: got sum=%h cout=%0b want 000021 0", sum, cout);
    end
    do_op(1'b0, 24'hFFFFFF, 24'h000001, 1'b0, tr);
    checks++;
    if (sum !== 24'h000000 || cout !== 1'b1 || tr !== 4'b1110) begin
      failures++;
      $display("FAIL dir_ripple: got sum=%h cout=%0b cin_trace=%b want 000000 1 1110", sum, cout, tr);
    end
    do_op(1'b1, 24'h00003F, 24'h00003C, 1'b1, tr);
    checks++;
    if (sum !== 24'h00007C || cout !== 1'b0 || done_id !== 1'b1) begin
      failures++;
      $display("FAIL dir_req1: got sum=%h cout=%0b id=%0b want 00007c 0 1", sum, cout, done_id);
    end
  endtask

  task automatic test_random();
    logic [SLICES-1:0] tr;
    for (int n = 0; n < 20; n++) begin
      do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), tr);
    end
  endtask

  task automatic test_contention();
    bit exp_id;
    @(posedge clk); #1;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom_range(0, 1));
    a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom_range(0, 1));
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 3 * (SLICES + 2); c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (c % (SLICES + 2) == 0) begin
        exp_id = model_pick1(1'b1, 1'b1);
        last_g = exp_id;
        exp_q.push_back(exp_id ? model_result(1'b1, a1, b1, cin1) : model_result(1'b0, a0, b0, cin0));
        checks++;
        if (gnt0 !== !exp_id || gnt1 !== exp_id) begin
          failures++;
          $display("FAIL contend_grant: cycle %0d got gnt0=%0b gnt1=%0b want id %0d", c, gnt0, gnt1, exp_id);
        end
      end else if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        checks++; failures++;
        $display("FAIL contend_spurious: cycle %0d got gnt0=%0b gnt1=%0b want 0 0", c, gnt0, gnt1);
      end
      if (c % (SLICES + 2) == SLICES + 1) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL contend_done: cycle %0d got done=%0b want 1", c, done);
          void'(exp_q.pop_front());
        end else begin
          check_done("contend_result");
        end
      end
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    @(posedge clk); #1;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL late_first_grant: got gnt0=%0b want 1", gnt0);
    end
    exp_q.push_back(model_result(1'b0, a0, b0, cin0));
    last_g = 1'b0;
    ra = W'($urandom); rb = W'($urandom);
    for (int c = 1; c <= 2 * SLICES + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 1'b0;
      if (c == 2) begin req1 = 1'b1; a1 = ra; b1 = rb; cin1 = 1'b1; end
      if (c == SLICES + 3) req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt1 !== (c == SLICES + 2) || gnt0 !== 1'b0) begin
        failures++;
        $display("FAIL late_grant: cycle %0d got gnt0=%0b gnt1=%0b", c, gnt0, gnt1);
      end
      if (c == SLICES + 2) begin
        exp_q.push_back(model_result(1'b1, ra, rb, 1'b1));
        last_g = 1'b1;
      end
      if (c == SLICES + 1 || c == 2 * SLICES + 3) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL late_done: cycle %0d got done=%0b want 1", c, done);
          void'(exp_q.pop_front());
        end else begin
          check_done("late_result");
        end
      end else if (done !== 1'b0) begin
        checks++; failures++;
        $display("FAIL late_spurious_done: cycle %0d got done=1 want 0", c);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [SLICES-1:0] tr;
    @(posedge clk); #1;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'b1; req0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req0 = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, add_a, add_b, add_cin, sum, cout, done, done_id, busy} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got sum=%h cout=%0b busy=%0b add_a=%h add_cin=%0b",
               sum, cout, busy, add_a, add_cin);
    end
    last_g = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < SLICES + 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
        checks++; failures++;
        $display("FAIL midrun_no_done: cycle %0d got done=%0b busy=%0b want 0 0", c, done, busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrun_queue: got %0d pending want 0", exp_q.size());
    end
    do_op(1'b0, 24'd8, 24'd7, 1'b0, tr);
    checks++;
    if (sum !== 24'h00000F) begin
      failures++;
      $display("FAIL midrun_after: got sum=%h want 00000f", sum);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin0 = 1'b0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_directed();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
